// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command sequencer.
package spi_cmd_pkg;

    // Command bytes recognised at the start of a command
    localparam logic [7:0] CMD_CONF  = 8'h2A;
    localparam logic [7:0] CMD_ADDR  = 8'h2B;
    localparam logic [7:0] CMD_DATA  = 8'h2C;
    localparam logic [7:0] CMD_FLUSH = 8'h2F;

    // Waveform timing defaults loaded at reset
    localparam logic [7:0] CFG_T0H_RST  = 8'h10;
    localparam logic [7:0] CFG_T1H_RST  = 8'h28;
    localparam logic [7:0] CFG_TBIT_RST = 8'h3C;

    // Parser states
    typedef enum logic [2:0] {
        IDLE,
        CONF,
        ADDR,
        DATA,
        DISCARD
    } state_t;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: parses SPI bytes into config loads, RAM pointer
// updates, pixel writes and frame flushes toward the LED output engine.
import spi_cmd_pkg::*;

module spi_cmd_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  spi_cs_n_in,
    input  logic                  byte_rdy_in,
    input  logic [7:0]            byte_data_in,
    input  logic                  led_busy_in,
    output logic                  ram_wr_en_out,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_out,
    output logic [7:0]            ram_wr_data_out,
    output logic [7:0]            cfg_t0h_out,
    output logic [7:0]            cfg_t1h_out,
    output logic [7:0]            cfg_tbit_out,
    output logic                  frame_start_out,
    output logic [ADDR_WIDTH:0]   frame_len_out
);

    localparam logic [ADDR_WIDTH:0]   CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [1:0]            byte_idx;
    logic [7:0]            t0h_stage;
    logic [7:0]            t1h_stage;
    logic [7:0]            addr_hi;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   data_cnt;
    logic                  flush_pend;
    logic                  cs_n_q;
    logic                  byte_ok;
    logic                  flush_cmd;

    // A byte counts while CS is low, and also on the very cycle CS rises
    // so the final byte of a session is not lost.
    assign byte_ok   = byte_rdy_in && (!spi_cs_n_in || !cs_n_q);
    assign flush_cmd = byte_ok && (state == IDLE) && (byte_data_in == CMD_FLUSH);

    // Remember the previous CS level to recognise the rising cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cs_n_q <= 1'b1;
        end else begin
            cs_n_q <= spi_cs_n_in;
        end
    end

    // Command parser: decodes bytes, loads config and pointer, writes RAM
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            byte_idx        <= 2'd0;
            t0h_stage       <= 8'h00;
            t1h_stage       <= 8'h00;
            addr_hi         <= 8'h00;
            wr_ptr          <= '0;
            data_cnt        <= '0;
            ram_wr_en_out   <= 1'b0;
            ram_wr_addr_out <= '0;
            ram_wr_data_out <= 8'h00;
            cfg_t0h_out     <= CFG_T0H_RST;
            cfg_t1h_out     <= CFG_T1H_RST;
            cfg_tbit_out    <= CFG_TBIT_RST;
            frame_len_out   <= '0;
        end else begin
            ram_wr_en_out <= 1'b0;
            if (byte_ok) begin
                case (state)
                    IDLE: begin
                        byte_idx <= 2'd0;
                        case (byte_data_in)
                            CMD_CONF:  state <= CONF;
                            CMD_ADDR:  state <= ADDR;
                            CMD_DATA:  state <= DATA;
                            CMD_FLUSH: begin
                                frame_len_out <= data_cnt;
                                data_cnt      <= '0;
                            end
                            default:   state <= DISCARD;
                        endcase
                    end
                    CONF: begin
                        case (byte_idx)
                            2'd0: begin
                                t0h_stage <= byte_data_in;
                                byte_idx  <= 2'd1;
                            end
                            2'd1: begin
                                t1h_stage <= byte_data_in;
                                byte_idx  <= 2'd2;
                            end
                            default: begin
                                cfg_t0h_out  <= t0h_stage;
                                cfg_t1h_out  <= t1h_stage;
                                cfg_tbit_out <= byte_data_in;
                                byte_idx     <= 2'd0;
                                state        <= IDLE;
                            end
                        endcase
                    end
                    ADDR: begin
                        if (byte_idx == 2'd0) begin
                            addr_hi  <= byte_data_in;
                            byte_idx <= 2'd1;
                        end else begin
                            wr_ptr   <= ADDR_WIDTH'({addr_hi, byte_data_in});
                            byte_idx <= 2'd0;
                            state    <= IDLE;
                        end
                    end
                    DATA: begin
                        ram_wr_en_out   <= 1'b1;
                        ram_wr_addr_out <= wr_ptr;
                        ram_wr_data_out <= byte_data_in;
                        wr_ptr          <= wr_ptr + PTR_ONE;
                        if (data_cnt != CNT_MAX) begin
                            data_cnt <= data_cnt + CNT_ONE;
                        end
                    end
                    DISCARD: begin
                        state <= DISCARD;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
            if (spi_cs_n_in) begin
                state    <= IDLE;
                byte_idx <= 2'd0;
            end
        end
    end

    // Flush scheduler: hold a pending frame start until the engine is idle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            flush_pend      <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            frame_start_out <= flush_pend && !led_busy_in;
            if (flush_cmd) begin
                flush_pend <= 1'b1;
            end else if (flush_pend && !led_busy_in) begin
                flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl with a command-level reference model.
module tb_spi_cmd_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          cs_n;
    logic          byte_rdy;
    logic [7:0]    byte_data;
    logic          led_busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    t0h;
    logic [7:0]    t1h;
    logic [7:0]    tbit;
    logic          frame_start;
    logic [AW:0]   frame_len;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int write_cnt = 0;

    // Reference model: what the sequencer should hold at command level
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_t0h;
    logic [7:0] m_t1h;
    logic [7:0] m_tbit;
    logic [7:0] data_q[$];

    spi_cmd_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .spi_cs_n_in     (cs_n),
        .byte_rdy_in     (byte_rdy),
        .byte_data_in    (byte_data),
        .led_busy_in     (led_busy),
        .ram_wr_en_out   (wr_en),
        .ram_wr_addr_out (wr_addr),
        .ram_wr_data_out (wr_data),
        .cfg_t0h_out     (t0h),
        .cfg_t1h_out     (t1h),
        .cfg_tbit_out    (tbit),
        .frame_start_out (frame_start),
        .frame_len_out   (frame_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame starts and RAM writes just after each active edge
    always @(posedge clk) begin
        #1;
        if (frame_start === 1'b1) start_cnt++;
        if (wr_en === 1'b1) write_cnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_cnt  = 0;
        m_t0h  = 8'h10;
        m_t1h  = 8'h28;
        m_tbit = 8'h3C;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic we,
                             output logic [AW-1:0] wa, output logic [7:0] wd);
        @(negedge clk);
        byte_rdy  = 1'b1;
        byte_data = b;
        @(negedge clk);
        byte_rdy  = 1'b0;
        we = wr_en;
        wa = wr_addr;
        wd = wr_data;
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
    endtask

    task automatic cs_end();
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_t0h"}, {24'h0, t0h}, {24'h0, m_t0h});
        chk({tag, "_t1h"}, {24'h0, t1h}, {24'h0, m_t1h});
        chk({tag, "_tbit"}, {24'h0, tbit}, {24'h0, m_tbit});
    endtask

    task automatic do_conf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic we; logic [AW-1:0] wa; logic [7:0] wd;
        cs_begin();
        send_byte(8'h2A, we, wa, wd);
        send_byte(a, we, wa, wd);
        send_byte(b, we, wa, wd);
        chk("conf_hold_t0h", {24'h0, t0h}, {24'h0, m_t0h});
        send_byte(c, we, wa, wd);
        m_t0h = a; m_t1h = b; m_tbit = c;
        chk_cfg("conf");
        chk("conf_nowrite", {31'h0, we}, 32'h0);
        cs_end();
    endtask

    task automatic do_addr(input logic [15:0] v);
        logic we; logic [AW-1:0] wa; logic [7:0] wd;
        cs_begin();
        send_byte(8'h2B, we, wa, wd);
        send_byte(v[15:8], we, wa, wd);
        send_byte(v[7:0], we, wa, wd);
        chk("addr_nowrite", {31'h0, we}, 32'h0);
        m_ptr = int'(v) % DEPTH;
        cs_end();
    endtask

    task automatic do_data();
        logic we; logic [AW-1:0] wa; logic [7:0] wd;
        cs_begin();
        send_byte(8'h2C, we, wa, wd);
        chk("data_cmd_nowrite", {31'h0, we}, 32'h0);
        foreach (data_q[i]) begin
            send_byte(data_q[i], we, wa, wd);
            chk("data_we", {31'h0, we}, 32'h1);
            chk("data_addr", 32'(wa), 32'(m_ptr));
            chk("data_byte", {24'h0, wd}, {24'h0, data_q[i]});
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
        end
        cs_end();
    endtask

    task automatic do_flush_free();
        logic we; logic [AW-1:0] wa; logic [7:0] wd;
        cs_begin();
        send_byte(8'h2F, we, wa, wd);
        chk("flush_len", 32'(frame_len), 32'(m_cnt));
        chk("flush_start_early", {31'h0, frame_start}, 32'h0);
        @(negedge clk);
        chk("flush_start", {31'h0, frame_start}, 32'h1);
        @(negedge clk);
        chk("flush_start_once", {31'h0, frame_start}, 32'h0);
        m_cnt = 0;
        cs_end();
    endtask

    initial begin
        logic we; logic [AW-1:0] wa; logic [7:0] wd;
        int s0;
        int w0;
        rst = 1'b1; cs_n = 1'b1; byte_rdy = 1'b0; byte_data = 8'h00; led_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_we", {31'h0, wr_en}, 32'h0);
        chk("rst_addr", 32'(wr_addr), 32'h0);
        chk("rst_data", {24'h0, wr_data}, 32'h0);
        chk("rst_start", {31'h0, frame_start}, 32'h0);
        chk("rst_len", 32'(frame_len), 32'h0);
        chk_cfg("rst");

        // Config load
        do_conf(8'h20, 8'h40, 8'h60);

        // Pointer load with wrap across the top of RAM
        do_addr(16'h03FE);
        data_q = '{8'hAA, 8'hBB, 8'hCC};
        do_data();
        do_flush_free();

        // Five bytes, new session, flush with engine idle
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_data();
        do_flush_free();

        // Flushes while busy collapse into one start with the newest length
        led_busy = 1'b1;
        s0 = start_cnt;
        cs_begin();
        send_byte(8'h2F, we, wa, wd);
        cs_end();
        chk("busy_len0", 32'(frame_len), 32'(m_cnt));
        data_q = '{8'h31, 8'h32, 8'h33};
        do_data();
        cs_begin();
        send_byte(8'h2F, we, wa, wd);
        cs_end();
        chk("busy_len3", 32'(frame_len), 32'(m_cnt));
        m_cnt = 0;
        repeat (5) @(negedge clk);
        chk("busy_no_start", 32'(start_cnt - s0), 32'h0);
        led_busy = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_one_start", 32'(start_cnt - s0), 32'h1);
        chk("busy_final_len", 32'(frame_len), 32'h3);

        // Partial payloads are dropped; unknown commands discard the session
        cs_begin();
        send_byte(8'h2A, we, wa, wd);
        send_byte(8'h11, we, wa, wd);
        cs_end();
        chk_cfg("partial_conf");
        cs_begin();
        send_byte(8'h2B, we, wa, wd);
        send_byte(8'h01, we, wa, wd);
        cs_end();
        data_q = '{8'h42};
        do_data();
        w0 = write_cnt;
        cs_begin();
        send_byte(8'h77, we, wa, wd);
        send_byte(8'h01, we, wa, wd);
        send_byte(8'h2C, we, wa, wd);
        send_byte(8'h55, we, wa, wd);
        cs_end();
        chk("discard_nowrite", 32'(write_cnt - w0), 32'h0);
        chk_cfg("discard");

        // Randomized command sessions
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: do_conf(8'($urandom), 8'($urandom), 8'($urandom));
                1: do_addr(16'($urandom));
                2: begin
                    data_q = {};
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                        data_q.push_back(8'($urandom));
                    end
                    do_data();
                end
                default: do_flush_free();
            endcase
        end

        // Byte counter saturates at the RAM depth
        do_flush_free();
        data_q = {};
        for (int k = 0; k < DEPTH + 6; k++) data_q.push_back(8'($urandom));
        do_data();
        do_flush_free();

        // Reset during streaming, with a pending flush that must be lost
        led_busy = 1'b1;
        cs_begin();
        send_byte(8'h2F, we, wa, wd);
        cs_end();
        cs_begin();
        send_byte(8'h2C, we, wa, wd);
        send_byte(8'hAA, we, wa, wd);
        chk("pre_rst_addr", 32'(wa), 32'(m_ptr));
        @(negedge clk);
        byte_rdy  = 1'b1;
        byte_data = 8'hBB;
        rst       = 1'b1;
        @(negedge clk);
        byte_rdy  = 1'b0;
        rst       = 1'b0;
        model_reset();
        chk("mid_rst_we", {31'h0, wr_en}, 32'h0);
        chk("mid_rst_addr", 32'(wr_addr), 32'h0);
        chk("mid_rst_len", 32'(frame_len), 32'h0);
        chk_cfg("mid_rst");
        s0 = start_cnt;
        led_busy = 1'b0;
        cs_end();
        repeat (4) @(negedge clk);
        chk("rst_flush_lost", 32'(start_cnt - s0), 32'h0);
        data_q = '{8'h99};
        do_data();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
